instr_fetch_fsm: RTL and testbench

Instruction-fetch controller for the 16-bit bus microcontroller. It sits directly upstream of the execution FSMs (ALU FSM and its siblings). Each fetch cycle gates the PC onto the bus, reads program memory, and loads the instruction register. It then presents the instruction word as `fullBitNum` with `IF_active` low and waits for the executing FSM's `done` before fetching again. Watchdogs on memory and execution latency trap the machine in an error state instead of hanging.

---
 rtl/micro_pkg.sv | 51 +++++
 rtl/fetch_watchdog.sv | 43 ++++
 rtl/instr_fetch_fsm.sv | 148 ++++++++++++++
 tb/tb_instr_fetch_fsm.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/micro_pkg.sv
// -----------------------------------------------------------------------------
// micro_pkg
// Shared definitions for the 16-bit bus microcontroller control FSMs.
//   - fetch_state_t : state encoding of the instruction-fetch controller
//   - OP_HALT       : opcode that stops the machine after it is fetched
//   - OP_ALU_MIN/MAX: opcode range decoded by the ALU execution FSM
//   - instr_t and field helpers: opcode[15:12], param1[11:6], param2[5:0]
// -----------------------------------------------------------------------------
package micro_pkg;

    localparam int INSTR_W = 16;

    localparam logic [3:0] OP_HALT    = 4'b0000;
    localparam logic [3:0] OP_ALU_MIN = 4'b1001;
    localparam logic [3:0] OP_ALU_MAX = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PC   = 3'd1,
        ST_RD   = 3'd2,
        ST_IR   = 3'd3,
        ST_EXEC = 3'd4,
        ST_HALT = 3'd5,
        ST_MERR = 3'd6,
        ST_XERR = 3'd7
    } fetch_state_t;

    typedef struct packed {
        logic [3:0] opcode;
        logic [5:0] param1;
        logic [5:0] param2;
    } instr_t;

    function automatic logic [3:0] get_opcode(input logic [INSTR_W-1:0] word);
        return word[15:12];
    endfunction

    function automatic logic [5:0] get_param1(input logic [INSTR_W-1:0] word);
        return word[11:6];
    endfunction

    function automatic logic [5:0] get_param2(input logic [INSTR_W-1:0] word);
        return word[5:0];
    endfunction

    // The ALU range runs to the top opcode, so only the lower bound needs a compare.
    function automatic logic is_alu_op(input logic [3:0] opcode);
        return opcode >= OP_ALU_MIN;
    endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// -----------------------------------------------------------------------------
// fetch_watchdog
// Loadable up-counter used as a latency watchdog by the fetch controller.
//   clk, rst   : clock, synchronous active-high reset
//   clr        : force count to zero (highest priority after rst)
//   load       : load count from load_val
//   en         : count up by one; holds once count reaches limit
//   load_val   : value taken on load
//   limit      : compare value
//   at_limit   : count == limit
// -----------------------------------------------------------------------------
module fetch_watchdog #(
    parameter int CW = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          load,
    input  logic          en,
    input  logic [CW-1:0] load_val,
    input  logic [CW-1:0] limit,
    output logic          at_limit
);

    logic [CW-1:0] count;

    // NOTE: state registers update with non-blocking assignments so every
    // flop samples the pre-edge value of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && !at_limit) begin
            count <= count + 1'b1;
        end
    end

    assign at_limit = (count == limit);

endmodule

// File: rtl/instr_fetch_fsm.sv
// -----------------------------------------------------------------------------
// instr_fetch_fsm
// Instruction-fetch controller: PC -> MAR, memory read, MDR -> IR, then parks
// in EXEC with IF_active low until an execution FSM reports done. Memory and
// execution latency are guarded by one shared watchdog; a timeout traps the
// machine in MERR or XERR until reset.
//   clk, rst     : clock, synchronous active-high reset
//   run          : start fetching (looked at in IDLE only)
//   bus_in       : shared data bus, carries the MDR value during IR
//   mem_ready    : program memory read data valid (looked at in RD only)
//   exec_done    : OR of execution FSM done pulses (looked at in EXEC only)
//   PC_out, MAR_in, MEM_rd, MDR_out, IR_in : bus/memory strobes
//   IF_active    : low only while an instruction executes
//   fullBitNum   : current instruction word, loaded when IR is left
//   halted, mem_err, exec_err : terminal-state flags
//   fetch_count  : instructions fetched since reset, wraps at 16 bits
// -----------------------------------------------------------------------------
module instr_fetch_fsm
    import micro_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int MEM_TIMEOUT  = 8,
    parameter int EXEC_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [WIDTH-1:0] bus_in,
    input  logic             mem_ready,
    input  logic             exec_done,
    output logic             PC_out,
    output logic             MAR_in,
    output logic             MEM_rd,
    output logic             MDR_out,
    output logic             IR_in,
    output logic             IF_active,
    output logic [WIDTH-1:0] fullBitNum,
    output logic             halted,
    output logic             mem_err,
    output logic             exec_err,
    output logic [15:0]      fetch_count
);

    localparam int WD_MAX = (MEM_TIMEOUT > EXEC_TIMEOUT) ? MEM_TIMEOUT : EXEC_TIMEOUT;
    localparam int WD_W   = $clog2(WD_MAX) + 1;

    fetch_state_t state, state_nxt;

    logic            wd_clr;
    logic            wd_en;
    logic            wd_hit;
    logic [WD_W-1:0] wd_limit;

    // The watchdog runs only in the two wait states and is held at zero
    // elsewhere, so it reads zero on the first cycle of RD and of EXEC.
    // Comparing against TIMEOUT-1 makes wd_hit true on the TIMEOUT-th wait
    // cycle; a ready/done on that same cycle still wins in the next-state logic.
    assign wd_en    = (state == ST_RD) || (state == ST_EXEC);
    assign wd_clr   = !wd_en;
    assign wd_limit = (state == ST_RD) ? WD_W'(MEM_TIMEOUT - 1) : WD_W'(EXEC_TIMEOUT - 1);

    fetch_watchdog #(
        .CW (WD_W)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clr      (wd_clr),
        .load     (1'b0),
        .en       (wd_en),
        .load_val ('0),
        .limit    (wd_limit),
        .at_limit (wd_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every signal driven here gets a default first; a path that left
    // one unassigned would infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (run) state_nxt = ST_PC;
            ST_PC:   state_nxt = ST_RD;
            ST_RD: begin
                if (mem_ready)   state_nxt = ST_IR;
                else if (wd_hit) state_nxt = ST_MERR;
            end
            ST_IR: begin
                if (get_opcode(bus_in) == OP_HALT) state_nxt = ST_HALT;
                else                               state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                if (exec_done)   state_nxt = ST_PC;
                else if (wd_hit) state_nxt = ST_XERR;
            end
            // HALT, MERR, XERR are terminal; only rst leaves them.
            default: state_nxt = state;
        endcase
    end

    // Moore outputs: decoded from the registered state only.
    always_comb begin
        PC_out    = 1'b0;
        MAR_in    = 1'b0;
        MEM_rd    = 1'b0;
        MDR_out   = 1'b0;
        IR_in     = 1'b0;
        IF_active = 1'b1;
        halted    = 1'b0;
        mem_err   = 1'b0;
        exec_err  = 1'b0;
        unique case (state)
            ST_PC: begin
                PC_out = 1'b1;
                MAR_in = 1'b1;
            end
            ST_RD:   MEM_rd = 1'b1;
            ST_IR: begin
                MDR_out = 1'b1;
                IR_in   = 1'b1;
            end
            ST_EXEC: IF_active = 1'b0;
            ST_HALT: halted    = 1'b1;
            ST_MERR: mem_err   = 1'b1;
            ST_XERR: exec_err  = 1'b1;
            default: ;
        endcase
    end

    // The instruction word is captured only on the edge that leaves IR, so it
    // stays stable for the whole of EXEC. HALT words are counted too.
    always_ff @(posedge clk) begin
        if (rst) begin
            fullBitNum  <= '0;
            fetch_count <= '0;
        end else if (state == ST_IR) begin
            fullBitNum  <= bus_in;
            fetch_count <= fetch_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_instr_fetch_fsm.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_fsm
// Self-checking bench for instr_fetch_fsm: directed scenarios with literal
// expectations, then randomized stimulus, all compared every cycle against a
// cycle-counting reference model of the fetch sequence.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_instr_fetch_fsm;

    localparam int WIDTH        = 16;
    localparam int MEM_TIMEOUT  = 8;
    localparam int EXEC_TIMEOUT = 64;

    // Model phases of a fetch.
    localparam int P_IDLE = 0;
    localparam int P_PC   = 1;
    localparam int P_RD   = 2;
    localparam int P_IR   = 3;
    localparam int P_EXEC = 4;
    localparam int P_HALT = 5;
    localparam int P_MERR = 6;
    localparam int P_XERR = 7;

    logic             clk = 1'b0;
    logic             rst;
    logic             run;
    logic [WIDTH-1:0] bus_in;
    logic             mem_ready;
    logic             exec_done;
    logic             PC_out;
    logic             MAR_in;
    logic             MEM_rd;
    logic             MDR_out;
    logic             IR_in;
    logic             IF_active;
    logic [WIDTH-1:0] fullBitNum;
    logic             halted;
    logic             mem_err;
    logic             exec_err;
    logic [15:0]      fetch_count;

    instr_fetch_fsm #(
        .WIDTH        (WIDTH),
        .MEM_TIMEOUT  (MEM_TIMEOUT),
        .EXEC_TIMEOUT (EXEC_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .bus_in      (bus_in),
        .mem_ready   (mem_ready),
        .exec_done   (exec_done),
        .PC_out      (PC_out),
        .MAR_in      (MAR_in),
        .MEM_rd      (MEM_rd),
        .MDR_out     (MDR_out),
        .IR_in       (IR_in),
        .IF_active   (IF_active),
        .fullBitNum  (fullBitNum),
        .halted      (halted),
        .mem_err     (mem_err),
        .exec_err    (exec_err),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Tracks which step of the fetch the machine is on and how many cycles
    // it has spent waiting in the current memory/execute wait.
    int          m_phase = P_IDLE;
    int          m_wait  = 0;
    logic [15:0] m_ir    = '0;
    logic [15:0] m_cnt   = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = P_IDLE;
            m_wait  = 0;
            m_ir    = '0;
            m_cnt   = '0;
        end else begin
            case (m_phase)
                P_IDLE: if (run) m_phase = P_PC;
                P_PC: begin
                    m_phase = P_RD;
                    m_wait  = 0;
                end
                P_RD: begin
                    m_wait++;
                    if (mem_ready)                 m_phase = P_IR;
                    else if (m_wait == MEM_TIMEOUT) m_phase = P_MERR;
                end
                P_IR: begin
                    m_ir    = bus_in;
                    m_cnt   = m_cnt + 16'd1;
                    m_phase = (bus_in[15:12] == 4'd0) ? P_HALT : P_EXEC;
                    m_wait  = 0;
                end
                P_EXEC: begin
                    m_wait++;
                    if (exec_done)                   m_phase = P_PC;
                    else if (m_wait == EXEC_TIMEOUT) m_phase = P_XERR;
                end
                default: ;
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(posedge clk) begin
        #1;
        if (cmp_en) begin
            check("PC_out",      PC_out,      m_phase == P_PC);
            check("MAR_in",      MAR_in,      m_phase == P_PC);
            check("MEM_rd",      MEM_rd,      m_phase == P_RD);
            check("MDR_out",     MDR_out,     m_phase == P_IR);
            check("IR_in",       IR_in,       m_phase == P_IR);
            check("IF_active",   IF_active,   m_phase != P_EXEC);
            check("halted",      halted,      m_phase == P_HALT);
            check("mem_err",     mem_err,     m_phase == P_MERR);
            check("exec_err",    exec_err,    m_phase == P_XERR);
            check("fullBitNum",  fullBitNum,  m_ir);
            check("fetch_count", fetch_count, m_cnt);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        step();
        rst       = 1'b1;
        run       = 1'b0;
        mem_ready = 1'b0;
        exec_done = 1'b0;
        bus_in    = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state_idle_PC_out"}, PC_out | MAR_in | MEM_rd | MDR_out | IR_in, 0);
        check({tag, "_IF_active"},   IF_active, 1);
        check({tag, "_flags"},       halted | mem_err | exec_err, 0);
        check({tag, "_fullBitNum"},  fullBitNum, 0);
        check({tag, "_fetch_count"}, fetch_count, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int rd;
        int ex;
        int hi;

        rst       = 1'b1;
        run       = 1'b0;
        mem_ready = 1'b0;
        exec_done = 1'b0;
        bus_in    = '0;

        do_reset();
        cmp_en = 1'b1;
        check_reset_values("reset");

        // Minimum fetch of 9042 with memory already ready.
        mem_ready = 1'b1;
        bus_in    = 16'h9042;
        run       = 1'b1;
        step();
        check("c1_PC_out", PC_out, 1);
        check("c1_MAR_in", MAR_in, 1);
        run = 1'b0;
        step();
        check("c2_MEM_rd", MEM_rd, 1);
        step();
        check("c3_IR_in", IR_in, 1);
        check("c3_IF_active", IF_active, 1);
        step();
        check("c4_IF_active", IF_active, 0);
        check("c4_fullBitNum", fullBitNum, 16'h9042);
        check("c4_fetch_count", fetch_count, 1);
        check("c4_model_cnt", m_cnt, 1);

        // Finish 9042, fetch A041 with ready held low for 3 RD cycles and a
        // stray done pulse during the first RD cycle.
        step();
        exec_done = 1'b1;
        mem_ready = 1'b0;
        bus_in    = 16'hA041;
        step();
        exec_done = 1'b0;
        check("done_to_PC", PC_out, 1);
        rd = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (MEM_rd) rd++;
            exec_done = (rd == 1);
            mem_ready = (rd >= 4);
            if (IR_in || mem_err) break;
        end
        exec_done = 1'b0;
        check("rdwait_reached_IR", IR_in, 1);
        check("rdwait_rd_cycles", rd, 4);
        check("rdwait_no_mem_err", mem_err, 0);
        step();
        check("a041_fullBitNum", fullBitNum, 16'hA041);
        check("a041_fetch_count", fetch_count, 2);

        // Done after 10 EXEC cycles, then IF_active high exactly 3 cycles.
        repeat (9) step();
        check("a041_still_exec", IF_active, 0);
        exec_done = 1'b1;
        mem_ready = 1'b1;
        bus_in    = 16'h1234;
        step();
        exec_done = 1'b0;
        check("a041_done_PC", PC_out, 1);
        hi = IF_active ? 1 : 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (!IF_active) break;
            hi++;
        end
        check("ifa_high_cycles", hi, 3);
        check("b2b_fullBitNum", fullBitNum, 16'h1234);

        // HALT instruction: counted, then run/exec_done ignored.
        step();
        exec_done = 1'b1;
        bus_in    = 16'h0000;
        step();
        exec_done = 1'b0;
        step();
        step();
        step();
        check("halt_flag", halted, 1);
        check("halt_IF_active", IF_active, 1);
        check("halt_fetch_count", fetch_count, 4);
        exec_done = 1'b1;
        run       = 1'b1;
        repeat (3) step();
        exec_done = 1'b0;
        run       = 1'b0;
        check("halt_sticky", halted, 1);
        check("halt_no_PC", PC_out, 0);
        check("halt_count_held", fetch_count, 4);

        // Memory never ready -> MERR after exactly MEM_TIMEOUT RD cycles.
        do_reset();
        check_reset_values("rst_from_halt");
        mem_ready = 1'b0;
        run       = 1'b1;
        step();
        run = 1'b0;
        rd  = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (MEM_rd) rd++;
            if (mem_err || IR_in) break;
        end
        check("merr_rd_cycles", rd, MEM_TIMEOUT);
        check("merr_flag", mem_err, 1);
        mem_ready = 1'b1;
        run       = 1'b1;
        repeat (5) step();
        run = 1'b0;
        check("merr_sticky", mem_err, 1);
        check("merr_IF_active", IF_active, 1);

        // Boundary: ready on the MEM_TIMEOUT-th RD cycle, done on the
        // EXEC_TIMEOUT-th EXEC cycle both count as success.
        do_reset();
        mem_ready = 1'b0;
        bus_in    = 16'hB00F;
        run       = 1'b1;
        step();
        run = 1'b0;
        rd  = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (MEM_rd) rd++;
            mem_ready = (rd == MEM_TIMEOUT);
            if (IR_in || mem_err) break;
        end
        check("rdlast_rd_cycles", rd, MEM_TIMEOUT);
        check("rdlast_IR", IR_in, 1);
        check("rdlast_no_mem_err", mem_err, 0);
        step();
        ex = 0;
        for (int i = 0; i < 100; i++) begin
            if (PC_out || exec_err) break;
            if (!IF_active) ex++;
            exec_done = (ex == EXEC_TIMEOUT);
            step();
        end
        exec_done = 1'b0;
        check("exlast_exec_cycles", ex, EXEC_TIMEOUT);
        check("exlast_PC", PC_out, 1);
        check("exlast_no_exec_err", exec_err, 0);

        // No done at all -> XERR after EXEC_TIMEOUT cycles.
        mem_ready = 1'b1;
        bus_in    = 16'hC123;
        step();
        step();
        step();
        ex = 0;
        for (int i = 0; i < 100; i++) begin
            if (exec_err) break;
            if (!IF_active) ex++;
            step();
        end
        check("xerr_exec_cycles", ex, EXEC_TIMEOUT);
        check("xerr_flag", exec_err, 1);

        // rst mid-EXEC and mid-RD returns to reset values on the next cycle.
        do_reset();
        check("xerr_cleared", exec_err, 0);
        mem_ready = 1'b1;
        bus_in    = 16'h5A5A;
        run       = 1'b1;
        step();
        run = 1'b0;
        repeat (3) step();
        check("pre_rst_exec", IF_active, 0);
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_values("rst_mid_exec");
        mem_ready = 1'b0;
        run       = 1'b1;
        step();
        run = 1'b0;
        step();
        step();
        check("pre_rst_rd", MEM_rd, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_values("rst_mid_rd");

        // Randomized traffic; the model compare runs every cycle.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            rst       = ($urandom_range(199) == 0);
            run       = ($urandom_range(3) == 0);
            mem_ready = ($urandom_range(2) == 0);
            exec_done = ($urandom_range(19) == 0);
            bus_in    = 16'($urandom);
            step();
        end
        rst       = 1'b0;
        exec_done = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
